avalon_burst_master: RTL and testbench
======================================

# avalon_burst_master

Avalon-MM burst initiator driving the same word-addressed memory bus our memory slaves answer on. Accepts one command at a time (read or write, word address, burst length, byte enables) and runs a single burst. Write data comes from a ready/valid stream and read data leaves on a valid-only stream. Used by test benches and the future DMA path to move blocks into and out of bus memory, with per-command completion, error and timeout status.

## Interface
- MAX_BURST, 16: largest legal cmd_len (1..31).
- TIMEOUT_CYCLES, 1024: idle cycles without bus progress before a burst is aborted.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cmd_valid / cmd_ready  in/out  1  command handshake; transfer when both are high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  30  start word address.
- cmd_len  in  5  beats in burst.
- cmd_byteenable  in  4  byte enables for every beat.
- wr_data  in  32  write beat data. wr_valid  in  1. wr_ready  out  1.
- rd_data  out  32  read beat data. rd_valid  out  1. No backpressure.
- done  out  1  one-cycle completion pulse.
- status_err  out  1  last command failed (bad length, nonzero response, or timeout); valid with done, held until next done.
- status_timeout  out  1  last command aborted by timeout; held like status_err.
- bus_address  out  30  burst start address, constant for the burst.
- bus_burstcount  out  5.
- bus_byteenable  out  4.
- bus_read / bus_write  out  1.
- bus_writedata  out  32.
- s_waitrequest  in  1.
- s_readdata  in  32.
- s_readdatavalid  in  1.
- s_writeresponsevalid  in  1.
- s_response  in  2  00 = OK.

## Operation
- States: IDLE, RD_REQ, RD_DATA, WR_BEAT, WR_RESP, FINISH.
- IDLE: cmd_ready=1. On handshake, latch the command.
  - cmd_len==0 or >MAX_BURST -> FINISH with err; no bus activity.
  - Otherwise go to WR_BEAT or RD_REQ.
- RD_REQ: bus_read=1, bus_* fields driven from the latched command. Held until a cycle with s_waitrequest=0 (accept), then -> RD_DATA.
- RD_DATA: each s_readdatavalid is one beat: rd_data<=s_readdata, rd_valid<=1 (registered). A beat counter counts to cmd_len, then -> FINISH.
- WR_BEAT: bus_write = wr_valid; bus_writedata = wr_data; wr_ready = ~s_waitrequest (combinational).
  - A beat is accepted when bus_write & ~s_waitrequest.
  - After cmd_len accepted beats -> WR_RESP.
  - bus_write may drop between beats when wr_valid is low.
- Write responses: one s_writeresponsevalid per beat, counted in both WR_BEAT and WR_RESP. WR_RESP -> FINISH once the count reaches cmd_len.
- Any response with s_response!=0 sets a sticky err for the command. The burst still runs to completion.
- Readdatavalid/writeresponsevalid outside an active burst are ignored.
- Timeout counter: cleared on command accept, on any accepted beat, and on any readdatavalid or writeresponsevalid. Increments otherwise in non-IDLE/FINISH states. Reaching TIMEOUT_CYCLES -> drop bus_read/bus_write that cycle, err=1, timeout=1, -> FINISH.
- FINISH: done=1 for one cycle; status_err/status_timeout update; -> IDLE.
- Counters are 5 bits. Len 31 is the maximum, so no wrap is possible.

## Timing
- Reset values (asynchronous): state IDLE, cmd_ready=1. All other outputs and counters 0: done, rd_valid, rd_data, status_*, bus_read, bus_write, bus_address, bus_burstcount, bus_byteenable, wr_ready.
- Reset mid-burst aborts immediately. Bus strobes drop asynchronously, with no done pulse.
- Command accepted at edge N: bus_read/bus_write (if wr_valid) asserted in cycle N+1.
- Read: bus_read deasserts the cycle after acceptance. rd_valid lags s_readdatavalid by exactly 1 cycle. done is asserted the cycle after the last rd_valid cycle.
- Write: done is asserted the cycle after the last writeresponsevalid is sampled.
- Bad length: done in cycle N+1 with status_err=1.
- cmd_ready=0 from N+1 until the cycle after done.
- If the last beat accept and a response land in the same cycle, both are counted.

## Test plan
- Read addr 0x100, len 4, be 0xF, against a memory preloaded 0xA0..0xA3 -> bus_read held through waitrequest, four rd_valid beats 0xA0..0xA3 in order, one done, status_err=0.
- Write addr 0x40, len 3, data 0x11/0x22/0x33 with wr_valid deasserted for 2 cycles after beat 1 -> bus_write gaps, three beats accepted, three responses, done, read-back matches.
- Write len 1, be 0x3, data 0xFFFFFFFF over existing 0x12345678 -> memory holds 0x1234FFFF.
- cmd_len=0, and cmd_len=17 -> done next cycle, status_err=1, bus_read/bus_write never assert.
- Read to an address no slave claims, TIMEOUT_CYCLES=16 -> bus_read drops after 16 idle cycles, done with status_err=1 and status_timeout=1, next command accepted normally.
- Assert rst_i in the middle of a 4-beat write -> outputs at reset values immediately, no done, clean 2-beat read afterwards.

Source files
------------

// File: rtl/avalon_burst_master.sv
// rtl/avalon_burst_master.sv - Avalon-MM single-command burst initiator
// Write beats come from a ready/valid stream, read beats leave on a valid-only stream.
module avalon_burst_master #(
  parameter int MAX_BURST      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [29:0] cmd_addr,
  input  logic [4:0]  cmd_len,
  input  logic [3:0]  cmd_byteenable,
  input  logic [31:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        status_err,
  output logic        status_timeout,
  output logic [29:0] bus_address,
  output logic [4:0]  bus_burstcount,
  output logic [3:0]  bus_byteenable,
  output logic        bus_read,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  input  logic        s_readdatavalid,
  input  logic        s_writeresponsevalid,
  input  logic [1:0]  s_response
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_BEAT = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [5:0]    MAX_LEN   = 6'(MAX_BURST);

  logic [2:0]    r_state;
  logic [29:0]   r_addr;
  logic [4:0]    r_len;
  logic [3:0]    r_be;
  logic [4:0]    r_beat_cnt;
  logic [4:0]    r_resp_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_err;
  logic          r_status_err;
  logic          r_status_tmo;
  logic [31:0]   r_rd_data;
  logic          r_rd_valid;

  logic       w_cmd_accept;
  logic       w_bad_len;
  logic       w_active;
  logic       w_tmo_hit;
  logic       w_bus_read;
  logic       w_bus_write;
  logic       w_rd_accept;
  logic       w_wr_accept;
  logic       w_rd_beat;
  logic       w_wr_resp;
  logic       w_resp_err;
  logic       w_progress;
  logic       w_err_final;
  logic [5:0] w_resp_total;
  logic [2:0] w_next;

  assign w_cmd_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_bad_len    = (cmd_len == 5'd0) || ({1'b0, cmd_len} > MAX_LEN);
  assign w_active     = (r_state == S_RD_REQ) || (r_state == S_RD_DATA) ||
                        (r_state == S_WR_BEAT) || (r_state == S_WR_RESP);
  // The strobes are masked in the timeout cycle so nothing can be accepted as we abort.
  assign w_tmo_hit    = w_active && (r_tmo_cnt == TMO_LIMIT);
  assign w_bus_read   = (r_state == S_RD_REQ) && !w_tmo_hit;
  assign w_bus_write  = (r_state == S_WR_BEAT) && wr_valid && !w_tmo_hit;
  assign w_rd_accept  = w_bus_read && !s_waitrequest;
  assign w_wr_accept  = w_bus_write && !s_waitrequest;
  assign w_rd_beat    = (r_state == S_RD_DATA) && s_readdatavalid;
  assign w_wr_resp    = ((r_state == S_WR_BEAT) || (r_state == S_WR_RESP)) && s_writeresponsevalid;
  assign w_resp_err   = (w_rd_beat || w_wr_resp) && (s_response != 2'b00);
  assign w_progress   = w_rd_accept || w_wr_accept || s_readdatavalid || s_writeresponsevalid;
  assign w_resp_total = {1'b0, r_resp_cnt} + {5'd0, w_wr_resp};
  assign w_err_final  = w_cmd_accept ? w_bad_len : (r_err || w_resp_err || w_tmo_hit);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_accept) begin
          if (w_bad_len)      w_next = S_FINISH;
          else if (cmd_write) w_next = S_WR_BEAT;
          else                w_next = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (w_tmo_hit)        w_next = S_FINISH;
        else if (w_rd_accept) w_next = S_RD_DATA;
      end
      // Leaves one cycle after the last beat so done trails the last rd_valid.
      S_RD_DATA: begin
        if (w_tmo_hit || (r_beat_cnt == r_len)) w_next = S_FINISH;
      end
      S_WR_BEAT: begin
        if (w_tmo_hit) w_next = S_FINISH;
        else if (w_wr_accept && ((r_beat_cnt + 5'd1) == r_len)) w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (w_tmo_hit || (w_resp_total == {1'b0, r_len})) w_next = S_FINISH;
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_be         <= '0;
      r_beat_cnt   <= '0;
      r_resp_cnt   <= '0;
      r_tmo_cnt    <= '0;
      r_err        <= 1'b0;
      r_status_err <= 1'b0;
      r_status_tmo <= 1'b0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_cmd_accept) begin
        r_addr     <= cmd_addr;
        r_len      <= cmd_len;
        r_be       <= cmd_byteenable;
        r_beat_cnt <= '0;
        r_resp_cnt <= '0;
      end else begin
        if (w_wr_accept || w_rd_beat) r_beat_cnt <= r_beat_cnt + 5'd1;
        if (w_wr_resp)                r_resp_cnt <= r_resp_cnt + 5'd1;
      end
      if (!w_active || w_progress) r_tmo_cnt <= '0;
      else                         r_tmo_cnt <= r_tmo_cnt + TW'(1);
      r_err <= w_err_final;
      if ((w_next == S_FINISH) && (r_state != S_FINISH)) begin
        r_status_err <= w_err_final;
        r_status_tmo <= w_tmo_hit;
      end
      r_rd_valid <= w_rd_beat;
      if (w_rd_beat) r_rd_data <= s_readdata;
    end
  end

  assign cmd_ready      = (r_state == S_IDLE);
  assign done           = (r_state == S_FINISH);
  assign wr_ready       = (r_state == S_WR_BEAT) && !s_waitrequest && !w_tmo_hit;
  assign rd_data        = r_rd_data;
  assign rd_valid       = r_rd_valid;
  assign status_err     = r_status_err;
  assign status_timeout = r_status_tmo;
  assign bus_address    = r_addr;
  assign bus_burstcount = r_len;
  assign bus_byteenable = r_be;
  assign bus_read       = w_bus_read;
  assign bus_write      = w_bus_write;
  assign bus_writedata  = wr_data;

endmodule

// File: tb/tb_avalon_burst_master.sv
// tb/tb_avalon_burst_master.sv - table-driven bench for avalon_burst_master
// A small word memory slave with waitrequest stalls answers the bursts.
module tb_avalon_burst_master;

  localparam int STALL_N = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [29:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic [3:0]  cmd_byteenable;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, done, status_err, status_timeout;
  logic [29:0] bus_address;
  logic [4:0]  bus_burstcount;
  logic [3:0]  bus_byteenable;
  logic        bus_read, bus_write;
  logic [31:0] bus_writedata;
  logic        s_waitrequest;
  logic [31:0] s_readdata;
  logic        s_readdatavalid, s_writeresponsevalid;
  logic [1:0]  s_response;

  avalon_burst_master #(.MAX_BURST(16), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_byteenable(cmd_byteenable),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .status_err(status_err), .status_timeout(status_timeout),
    .bus_address(bus_address), .bus_burstcount(bus_burstcount),
    .bus_byteenable(bus_byteenable), .bus_read(bus_read), .bus_write(bus_write),
    .bus_writedata(bus_writedata), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid),
    .s_writeresponsevalid(s_writeresponsevalid), .s_response(s_response)
  );

  always #5 clk_i = ~clk_i;

  // Slave: 0x000-0x1FF normal, 0x300-0x37F answers with an error response, rest unclaimed.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  int          sl_stall;
  logic [29:0] sl_rd_addr;
  logic [4:0]  sl_rd_left;
  logic        sl_rd_err;
  logic [4:0]  sl_wbeat;
  logic        w_claim;
  logic [9:0]  w_wa;

  assign w_claim = (bus_address < 30'h200) || ((bus_address >= 30'h300) && (bus_address < 30'h380));
  assign s_waitrequest = !(w_claim && (sl_stall >= STALL_N));
  assign w_wa = bus_address[9:0] + {5'd0, sl_wbeat};

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sl_stall <= 0;
      sl_rd_addr <= '0;
      sl_rd_left <= '0;
      sl_rd_err <= 1'b0;
      sl_wbeat <= '0;
      s_readdata <= '0;
      s_readdatavalid <= 1'b0;
      s_writeresponsevalid <= 1'b0;
      s_response <= 2'b00;
    end else begin
      if ((bus_read || bus_write) && s_waitrequest) sl_stall <= sl_stall + 1;
      else sl_stall <= 0;
      s_readdatavalid <= 1'b0;
      if (sl_rd_left != 5'd0) begin
        s_readdatavalid <= 1'b1;
        s_readdata <= mem[sl_rd_addr[9:0]];
        s_response <= sl_rd_err ? 2'b10 : 2'b00;
        sl_rd_addr <= sl_rd_addr + 30'd1;
        sl_rd_left <= sl_rd_left - 5'd1;
      end
      if (bus_read && !s_waitrequest) begin
        sl_rd_addr <= bus_address;
        sl_rd_left <= bus_burstcount;
        sl_rd_err <= (bus_address >= 30'h300);
      end
      s_writeresponsevalid <= bus_write && !s_waitrequest;
      if (bus_write && !s_waitrequest) begin
        s_response <= 2'b00;
        sl_wbeat <= ((sl_wbeat + 5'd1) == bus_burstcount) ? 5'd0 : sl_wbeat + 5'd1;
      end
    end
  end

  always @(posedge clk_i) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus_write && !s_waitrequest)
      for (int b = 0; b < 4; b++)
        if (bus_byteenable[b]) mem[w_wa][b*8 +: 8] <= bus_writedata[b*8 +: 8];
  end

  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [4:0]  len;
    logic [3:0]  be;
    logic [31:0] d0;
    logic [31:0] dstep;
    int          gap_after;
    int          exp_gap;
    bit          exp_err;
    bit          exp_tmo;
    int          exp_beats;
    int          exp_rdcyc;
    bit          exp_nobus;
    logic [31:0] m0;
    logic [31:0] mstep;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    @(posedge clk_i); #1;
    pl_en = 1'b0;
  endtask

  task automatic run_cmd(input vec_t v);
    int idx = 0, gap_left = 0, dones = 0, beats = 0, rdv_n = 0, rdcyc = 0;
    int wgap = 0, wresp = 0, rdv_lag = 0, last_rdv = 0, last_wrv = 0;
    int done_cyc = 0, acc_cyc = 0, crdy_bad = 0;
    bit acc_pend = 1'b0, accepted = 1'b0, prev_srdv = 1'b0, saw_bus = 1'b0, fin = 1'b0;
    bit err_s = 1'b0, tmo_s = 1'b0;
    logic [31:0] got [32];
    logic [29:0] a;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(posedge clk_i); #1;
      if (acc_pend) begin
        idx++;
        if (idx == v.gap_after + 1) gap_left = 2;
      end
      cmd_valid = !accepted;
      cmd_write = v.wr;
      cmd_addr = v.addr;
      cmd_len = v.len;
      cmd_byteenable = v.be;
      if (gap_left > 0) begin
        wr_valid = 1'b0;
        gap_left--;
      end else begin
        wr_valid = v.wr && (idx < int'(v.len));
      end
      wr_data = v.d0 + 32'(idx) * v.dstep;
      @(negedge clk_i);
      acc_pend = wr_valid && wr_ready;
      if (cmd_valid && cmd_ready) begin
        accepted = 1'b1;
        acc_cyc = c;
      end else if (accepted && cmd_ready) begin
        crdy_bad++;
      end
      if (bus_read || bus_write) saw_bus = 1'b1;
      if (bus_read) rdcyc++;
      if (bus_write && !s_waitrequest) beats++;
      if (v.wr && accepted && beats >= 1 && beats < int'(v.len) && !bus_write) wgap++;
      if (rd_valid) begin
        if (rdv_n < 32) got[rdv_n] = rd_data;
        rdv_n++;
        last_rdv = c;
      end
      if (rd_valid != prev_srdv) rdv_lag++;
      prev_srdv = s_readdatavalid;
      if (s_writeresponsevalid) begin
        wresp++;
        last_wrv = c;
      end
      if (done) begin
        dones++;
        done_cyc = c;
        err_s = status_err;
        tmo_s = status_timeout;
        fin = 1'b1;
      end
    end
    @(posedge clk_i); #1;
    cmd_valid = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk_i);
    chk("done_once", 32'(dones), 1);
    chk("status_err", 32'(err_s), 32'(v.exp_err));
    chk("status_timeout", 32'(tmo_s), 32'(v.exp_tmo));
    chk("cmd_ready_while_busy", 32'(crdy_bad), 0);
    chk("after_done_ready_status", {28'd0, cmd_ready, done, status_err, status_timeout},
        {28'd0, 1'b1, 1'b0, v.exp_err, v.exp_tmo});
    if (v.exp_nobus) begin
      chk("badlen_no_bus", 32'(saw_bus), 0);
      chk("badlen_done_latency", 32'(done_cyc - acc_cyc), 1);
    end else if (!v.wr) begin
      chk("rd_beats", 32'(rdv_n), 32'(v.exp_beats));
      for (int i = 0; i < rdv_n && i < v.exp_beats; i++)
        chk("rd_data", got[i], v.d0 + 32'(i) * v.dstep);
      chk("rd_req_cycles", 32'(rdcyc), 32'(v.exp_rdcyc));
      chk("rd_valid_lag", 32'(rdv_lag), 0);
      if (v.exp_beats > 0) chk("rd_done_latency", 32'(done_cyc - last_rdv), 1);
    end else begin
      chk("wr_beats", 32'(beats), 32'(v.len));
      chk("wr_responses", 32'(wresp), 32'(v.len));
      chk("wr_done_latency", 32'(done_cyc - last_wrv), 1);
      chk("wr_gap_cycles", 32'(wgap), 32'(v.exp_gap));
      for (int i = 0; i < int'(v.len); i++) begin
        a = v.addr + 30'(i);
        chk("wr_mem", mem[a[9:0]], v.m0 + 32'(i) * v.mstep);
      end
    end
  endtask

  vec_t vecs [10];
  vec_t rd_after_rst;
  int   nb;
  int   rst_dones;

  initial begin
    vecs[0] = '{1'b0, 30'h100, 5'd4,  4'hF, 32'hA0, 32'h1, -1, 0, 1'b0, 1'b0, 4, 3, 1'b0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 30'h040, 5'd3,  4'hF, 32'h11, 32'h11, 0, 2, 1'b0, 1'b0, 0, -1, 1'b0, 32'h11, 32'h11};
    vecs[2] = '{1'b0, 30'h040, 5'd3,  4'hF, 32'h11, 32'h11, -1, 0, 1'b0, 1'b0, 3, 3, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{1'b1, 30'h050, 5'd1,  4'h3, 32'hFFFFFFFF, 32'h0, -1, 0, 1'b0, 1'b0, 0, -1, 1'b0, 32'h1234FFFF, 32'h0};
    vecs[4] = '{1'b0, 30'h100, 5'd0,  4'hF, 32'h0, 32'h0, -1, 0, 1'b1, 1'b0, 0, -1, 1'b1, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 30'h060, 5'd17, 4'hF, 32'h0, 32'h0, -1, 0, 1'b1, 1'b0, 0, -1, 1'b1, 32'h0, 32'h0};
    vecs[6] = '{1'b0, 30'h280, 5'd2,  4'hF, 32'h0, 32'h0, -1, 0, 1'b1, 1'b1, 0, 16, 1'b0, 32'h0, 32'h0};
    vecs[7] = '{1'b0, 30'h100, 5'd2,  4'hF, 32'hA0, 32'h1, -1, 0, 1'b0, 1'b0, 2, 3, 1'b0, 32'h0, 32'h0};
    vecs[8] = '{1'b0, 30'h300, 5'd2,  4'hF, 32'hE0, 32'h1, -1, 0, 1'b1, 1'b0, 2, 3, 1'b0, 32'h0, 32'h0};
    vecs[9] = '{1'b0, 30'h000, 5'd16, 4'hF, 32'hC00, 32'h1, -1, 0, 1'b0, 1'b0, 16, 3, 1'b0, 32'h0, 32'h0};
    rd_after_rst = '{1'b0, 30'h100, 5'd2, 4'hF, 32'hA0, 32'h1, -1, 0, 1'b0, 1'b0, 2, 3, 1'b0, 32'h0, 32'h0};

    rst_i = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    cmd_byteenable = '0;
    wr_data = '0;
    wr_valid = 1'b0;
    for (int i = 0; i < 4; i++) preload(10'h100 + 10'(i), 32'hA0 + 32'(i));
    preload(10'h050, 32'h12345678);
    preload(10'h300, 32'hE0);
    preload(10'h301, 32'hE1);
    for (int i = 0; i < 16; i++) preload(10'(i), 32'hC00 + 32'(i));
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("reset_flags", {24'd0, cmd_ready, done, rd_valid, bus_read, bus_write, wr_ready,
        status_err, status_timeout}, 32'h80);
    chk("reset_bus_address", {2'd0, bus_address}, 0);
    chk("reset_burst_be", {23'd0, bus_burstcount, bus_byteenable}, 0);
    chk("reset_rd_data", rd_data, 0);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i]);

    // Reset in the middle of a 4-beat write, after two beats have gone out.
    nb = 0;
    @(posedge clk_i); #1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 30'h060;
    cmd_len = 5'd4;
    cmd_byteenable = 4'hF;
    wr_valid = 1'b1;
    wr_data = 32'h5A5A0000;
    for (int c = 0; c < 100 && nb < 2; c++) begin
      @(negedge clk_i);
      if (wr_valid && wr_ready) nb++;
      @(posedge clk_i); #1;
      cmd_valid = 1'b0;
      wr_data = 32'h5A5A0000 + 32'(nb);
    end
    chk("mid_rst_beats_before", 32'(nb), 2);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_rst_flags", {24'd0, cmd_ready, done, rd_valid, bus_read, bus_write, wr_ready,
        status_err, status_timeout}, 32'h80);
    chk("mid_rst_bus_address", {2'd0, bus_address}, 0);
    wr_valid = 1'b0;
    rst_dones = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      if (done) rst_dones++;
    end
    rst_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_i);
      if (done) rst_dones++;
    end
    chk("mid_rst_no_done", 32'(rst_dones), 0);
    run_cmd(rd_after_rst);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
